turbo_out_arbiter: RTL and testbench
====================================

// Module: turbo_out_arbiter
// PURPOSE
//  Merges the decoded output streams of NUM_TURBO parallel turbo decoder instances into one stream.
//  Arbitration is round-robin and packet-atomic: once a channel wins, it keeps the grant from sop to eop.
//  Sits between the decoder bank (source_* ports) and the downstream CRC/result sink.
//  Tags every beat with its channel index so the result sink can rebuild the order of the round-robin distributor.
// PARAMETERS
//  NUM_TURBO  4   number of decoder instances (2..16)
//  DATA_W     8   width of source_data_s per decoder
//  CHAN_W     4   width of channel index; must satisfy 2**CHAN_W >= NUM_TURBO
// PORTS
//  clk            in   1                  system clock
//  reset_n        in   1                  asynchronous active-low reset
//  src_valid      in   NUM_TURBO          per-decoder source_valid
//  src_ready      out  NUM_TURBO          per-decoder source_ready
//  src_sop        in   NUM_TURBO          per-decoder source_sop
//  src_eop        in   NUM_TURBO          per-decoder source_eop
//  src_error      in   2*NUM_TURBO        per-decoder source_error, channel i at [2i+1:2i]
//  src_crc_pass   in   NUM_TURBO          per-decoder crc_pass, sampled on the eop beat
//  src_data       in   DATA_W*NUM_TURBO   per-decoder source_data_s, channel i at [DATA_W*i +: DATA_W]
//  out_valid      out  1                  merged stream valid
//  out_ready      in   1                  downstream ready
//  out_sop/out_eop out 1                  merged framing
//  out_error      out  2                  error of the granted channel
//  out_crc_pass   out  1                  crc_pass of the granted channel; meaningful only on out_eop
//  out_data       out  DATA_W             merged data
//  out_chan       out  CHAN_W             channel index of the current beat
//  proto_err      out  1                  sticky; set on a framing violation (see BEHAVIOUR)
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; rr pointer = 0; proto_err = 0. Reset mid-packet discards that packet.
//  Output stage: one register. It loads when (!out_valid || out_ready); latency is 1 cycle from src to out.
//  src_ready[g] = (state==BUSY) && (grant==g) && (!out_valid || out_ready). All other bits of src_ready are 0.
//  FSM IDLE: each cycle, pick the first channel i with src_valid[i] && src_sop[i].
//   Search order starts at rr_ptr and wraps modulo NUM_TURBO.
//   If a channel is found: grant <= i, go to BUSY. The sop beat is not consumed in IDLE
//   (1 cycle of arbitration bubble).
//  FSM BUSY: beats of the granted channel are transferred on src_valid[g] && src_ready[g].
//   On the accepted beat with src_eop: rr_ptr <= (g+1) mod NUM_TURBO and state <= IDLE.
//  Single-beat packet (sop && eop on the same beat): legal; the packet occupies one BUSY cycle.
//  Framing violations set proto_err (sticky) and do not stall arbitration:
//   - In BUSY, an accepted beat with src_sop that is not the first beat of the packet.
//   - In IDLE, src_valid[i] && !src_sop[i]. Such a channel is never granted and stays stalled.
//  Simultaneous requests: exactly one grant per arbitration. Other requesters hold valid, since src_ready is 0.
//  Fairness: with all channels requesting, grants go in order ptr, ptr+1, ...
//   Maximum wait is (NUM_TURBO-1) packets.
//  out_chan/out_error/out_crc_pass are registered together with out_data and are held while out_valid && !out_ready.
// CONFIGURATION
//  TURBO_ARB_STATS_EN defined: adds output pkt_cnt [16*NUM_TURBO] and output crc_fail_cnt [16*NUM_TURBO].
//   Both are per-channel counters, updated on each accepted eop beat. They wrap at 16'hFFFF to 0 and reset to 0.
//  TURBO_ARB_STATS_EN undefined: these ports and counters do not exist. All other behaviour is identical.
// STRUCTURE
//  Package turbo_arb_pkg holds:
//   - the state enum {IDLE, BUSY}
//   - CHAN_W and the default NUM_TURBO/DATA_W
//   - the lane-slice helper for src_data/src_error.
//  Sub-module turbo_rr_pick: combinational rotating priority picker.
//   Inputs req[NUM_TURBO] and ptr. Outputs found and idx.
//   Reused by the input-side distributor.
// TESTING
//  1. Single request: ch2 sends a 3-beat packet D=0x11,0x22,0x33 with out_ready=1.
//     -> out carries 0x11/sop, 0x22, 0x33/eop with out_chan=2. First out beat 2 cycles after src_valid.
//  2. All 4 channels request 2-beat packets from reset.
//     -> grant order 0,1,2,3, then 0 again if a channel re-requests. No interleaving of beats between packets.
//  3. Backpressure: out_ready toggles 1,0,0,1 mid-packet.
//     -> out_data is stable while stalled; src_ready[g]=0 during the stall; no beat lost or duplicated.
//  4. Single-beat packets (sop=eop=1) on ch1 and ch3 simultaneously with rr_ptr=2.
//     -> ch3 is granted first, then ch1. rr_ptr ends at 2.
//  5. ch0 asserts valid without sop in IDLE.
//     -> proto_err=1 and ch0 is never granted. ch1 traffic continues normally.
//  6. Assert reset_n=0 mid-packet on ch2.
//     -> outputs go 0 immediately; after release, ch2 must re-present sop to be granted.
//     With TURBO_ARB_STATS_EN: 5 packets on ch1, 2 of them with crc_pass=0
//     -> pkt_cnt[1]=5, crc_fail_cnt[1]=2.

Source files
------------

// File: rtl/turbo_arb_pkg.sv
// Shared types, default sizes and the lane-slice helper for the turbo output arbiter.
// Used by turbo_out_arbiter and turbo_rr_pick.
package turbo_arb_pkg;

    localparam int TURBO_NUM_DEF    = 4;
    localparam int TURBO_DATA_W_DEF = 8;
    localparam int TURBO_CHAN_W     = 4;

    // The helper works on a wide carrier so that any lane width up to LANE_MAX_W
    // and any bus up to BUS_MAX_W can share one function.
    localparam int LANE_MAX_W = 64;
    localparam int BUS_MAX_W  = 1024;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    function automatic logic [LANE_MAX_W-1:0] lane_slice(
        input logic [BUS_MAX_W-1:0] bus,
        input int unsigned          lane_w,
        input int unsigned          idx
    );
        logic [LANE_MAX_W-1:0] mask;
        mask = (LANE_MAX_W'(1) << lane_w) - LANE_MAX_W'(1);
        return LANE_MAX_W'(bus >> (lane_w * idx)) & mask;
    endfunction

endpackage

// File: rtl/turbo_rr_pick.sv
// Combinational rotating-priority picker: first set bit of req at or after ptr, wrapping mod N.
// Shared with the input-side distributor.
module turbo_rr_pick #(
    parameter int N = 4,
    parameter int W = 4
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] idx
);

    logic [N-1:0] rot;
    int unsigned  sum;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        sum   = 0;
        // rot[k] is the request of channel (ptr + k) mod N
        rot   = N'({req, req} >> ptr);
        for (int k = 0; k < N; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                sum   = 32'(ptr) + 32'(k);
                if (sum >= 32'(N)) begin
                    sum = sum - 32'(N);
                end
                idx = W'(sum);
            end
        end
    end

endmodule

// File: rtl/turbo_out_arbiter.sv
// Packet-atomic round-robin merge of NUM_TURBO decoder output streams, tagged with channel index.
// Optional per-channel packet / CRC-fail counters when TURBO_ARB_STATS_EN is defined.
//
//  state | meaning
//  ------+---------------------------------------------------------------
//  IDLE  | search for a channel presenting sop, starting at rr_ptr
//  BUSY  | forward beats of the granted channel until its eop is accepted
module turbo_out_arbiter
    import turbo_arb_pkg::*;
#(
    parameter int NUM_TURBO = TURBO_NUM_DEF,
    parameter int DATA_W    = TURBO_DATA_W_DEF,
    parameter int CHAN_W    = TURBO_CHAN_W
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NUM_TURBO-1:0]        src_valid,
    output logic [NUM_TURBO-1:0]        src_ready,
    input  logic [NUM_TURBO-1:0]        src_sop,
    input  logic [NUM_TURBO-1:0]        src_eop,
    input  logic [2*NUM_TURBO-1:0]      src_error,
    input  logic [NUM_TURBO-1:0]        src_crc_pass,
    input  logic [DATA_W*NUM_TURBO-1:0] src_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_sop,
    output logic                        out_eop,
    output logic [1:0]                  out_error,
    output logic                        out_crc_pass,
    output logic [DATA_W-1:0]           out_data,
    output logic [CHAN_W-1:0]           out_chan,
`ifdef TURBO_ARB_STATS_EN
    output logic [16*NUM_TURBO-1:0]     pkt_cnt,
    output logic [16*NUM_TURBO-1:0]     crc_fail_cnt,
`endif
    output logic                        proto_err
);

    localparam logic [0:0] ST_IDLE = IDLE;
    localparam logic [0:0] ST_BUSY = BUSY;

    logic [0:0]           state;
    logic [CHAN_W-1:0]    grant;
    logic [CHAN_W-1:0]    rr_ptr;
    logic [CHAN_W-1:0]    next_ptr;
    logic                 first_beat;

    logic [NUM_TURBO-1:0] grant_oh;
    logic [NUM_TURBO-1:0] sop_req;
    logic                 pick_found;
    logic [CHAN_W-1:0]    pick_idx;

    logic                 load_en;
    logic                 beat_acc;
    logic                 g_valid;
    logic                 g_sop;
    logic                 g_eop;
    logic                 g_crc;
    logic [1:0]           g_err;
    logic [DATA_W-1:0]    g_data;

    always_comb begin
        grant_oh = '0;
        for (int i = 0; i < NUM_TURBO; i++) begin
            grant_oh[i] = (grant == CHAN_W'(i));
        end
    end

    assign sop_req  = src_valid & src_sop;
    assign load_en  = !out_valid || out_ready;

    assign g_valid  = |(src_valid & grant_oh);
    assign g_sop    = |(src_sop & grant_oh);
    assign g_eop    = |(src_eop & grant_oh);
    assign g_crc    = |(src_crc_pass & grant_oh);
    assign g_err    = 2'(lane_slice(BUS_MAX_W'(src_error), 2, 32'(grant)));
    assign g_data   = DATA_W'(lane_slice(BUS_MAX_W'(src_data), DATA_W, 32'(grant)));

    assign src_ready = ((state == ST_BUSY) && load_en) ? grant_oh : '0;
    assign beat_acc  = (state == ST_BUSY) && load_en && g_valid;

    assign next_ptr = (grant == CHAN_W'(NUM_TURBO - 1)) ? '0 : grant + CHAN_W'(1);

    turbo_rr_pick #(
        .N (NUM_TURBO),
        .W (CHAN_W)
    ) u_pick (
        .req   (sop_req),
        .ptr   (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            grant      <= '0;
            rr_ptr     <= '0;
            first_beat <= 1'b0;
            proto_err  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // A mid-packet beat offered while idle is never granted; flag it and move on.
                    if (|(src_valid & ~src_sop)) begin
                        proto_err <= 1'b1;
                    end
                    if (pick_found) begin
                        grant      <= pick_idx;
                        first_beat <= 1'b1;
                        state      <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (beat_acc) begin
                        first_beat <= 1'b0;
                        if (g_sop && !first_beat) begin
                            proto_err <= 1'b1;
                        end
                        if (g_eop) begin
                            rr_ptr <= next_ptr;
                            state  <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Single output register; sideband fields travel with the data and hold under backpressure.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid    <= 1'b0;
            out_sop      <= 1'b0;
            out_eop      <= 1'b0;
            out_error    <= '0;
            out_crc_pass <= 1'b0;
            out_data     <= '0;
            out_chan     <= '0;
        end else if (load_en) begin
            out_valid <= beat_acc;
            if (beat_acc) begin
                out_sop      <= g_sop;
                out_eop      <= g_eop;
                out_error    <= g_err;
                out_crc_pass <= g_crc;
                out_data     <= g_data;
                out_chan     <= grant;
            end
        end
    end

`ifdef TURBO_ARB_STATS_EN
    logic [15:0] pkt_cnt_r      [NUM_TURBO];
    logic [15:0] crc_fail_cnt_r [NUM_TURBO];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_TURBO; i++) begin
                pkt_cnt_r[i]      <= '0;
                crc_fail_cnt_r[i] <= '0;
            end
        end else if (beat_acc && g_eop) begin
            for (int i = 0; i < NUM_TURBO; i++) begin
                if (grant_oh[i]) begin
                    pkt_cnt_r[i] <= pkt_cnt_r[i] + 16'd1;
                    if (!g_crc) begin
                        crc_fail_cnt_r[i] <= crc_fail_cnt_r[i] + 16'd1;
                    end
                end
            end
        end
    end

    for (genvar gi = 0; gi < NUM_TURBO; gi++) begin : g_stats
        assign pkt_cnt[16*gi +: 16]      = pkt_cnt_r[gi];
        assign crc_fail_cnt[16*gi +: 16] = crc_fail_cnt_r[gi];
    end
`endif

endmodule

// File: tb/tb_turbo_out_arbiter.sv
// Scoreboard bench for turbo_out_arbiter: per-channel source queues drive the DUT,
// expected beats are queued in predicted grant order and checked as they leave.
module tb_turbo_out_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int CW = 4;

    typedef struct packed {
        logic [CW-1:0] chan;
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
        logic [1:0]    err;
        logic          crc;
    } beat_t;

    logic              clk;
    logic              reset_n;
    logic [N-1:0]      src_valid;
    logic [N-1:0]      src_ready;
    logic [N-1:0]      src_sop;
    logic [N-1:0]      src_eop;
    logic [2*N-1:0]    src_error;
    logic [N-1:0]      src_crc_pass;
    logic [DW*N-1:0]   src_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_sop;
    logic              out_eop;
    logic [1:0]        out_error;
    logic              out_crc_pass;
    logic [DW-1:0]     out_data;
    logic [CW-1:0]     out_chan;
    logic              proto_err;
`ifdef TURBO_ARB_STATS_EN
    logic [16*N-1:0]   pkt_cnt;
    logic [16*N-1:0]   crc_fail_cnt;
`endif

    beat_t srcq [N][$];
    beat_t expq [$];
    beat_t mon_e;
    beat_t drv_b;
    logic [N-1:0] acc;
    int n_tests;
    int n_fail;

    turbo_out_arbiter #(
        .NUM_TURBO (N),
        .DATA_W    (DW),
        .CHAN_W    (CW)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .src_valid    (src_valid),
        .src_ready    (src_ready),
        .src_sop      (src_sop),
        .src_eop      (src_eop),
        .src_error    (src_error),
        .src_crc_pass (src_crc_pass),
        .src_data     (src_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sop      (out_sop),
        .out_eop      (out_eop),
        .out_error    (out_error),
        .out_crc_pass (out_crc_pass),
        .out_data     (out_data),
        .out_chan     (out_chan),
`ifdef TURBO_ARB_STATS_EN
        .pkt_cnt      (pkt_cnt),
        .crc_fail_cnt (crc_fail_cnt),
`endif
        .proto_err    (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_src();
        for (int c = 0; c < N; c++) begin
            if (srcq[c].size() > 0) begin
                drv_b = srcq[c][0];
                src_valid[c]            = 1'b1;
                src_sop[c]              = drv_b.sop;
                src_eop[c]              = drv_b.eop;
                src_crc_pass[c]         = drv_b.crc;
                src_error[2*c +: 2]     = drv_b.err;
                src_data[DW*c +: DW]    = drv_b.data;
            end else begin
                src_valid[c]            = 1'b0;
                src_sop[c]              = 1'b0;
                src_eop[c]              = 1'b0;
                src_crc_pass[c]         = 1'b0;
                src_error[2*c +: 2]     = 2'b00;
                src_data[DW*c +: DW]    = '0;
            end
        end
    endtask

    // Handshakes are sampled mid-cycle, sources advance just after the clock edge.
    initial begin
        forever begin
            @(negedge clk);
            acc = src_valid & src_ready;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int c = 0; c < N; c++) begin
                if (acc[c] && srcq[c].size() > 0) void'(srcq[c].pop_front());
            end
            acc = '0;
            drive_src();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (reset_n && out_valid && out_ready) begin
                n_tests++;
                if (expq.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_beat: got chan=%0d data=%h, required no beat", out_chan, out_data);
                end else begin
                    mon_e = expq.pop_front();
                    if ({out_chan, out_data, out_sop, out_eop, out_error, out_crc_pass} !== mon_e) begin
                        n_fail++;
                        $display("FAIL out_beat: got chan=%0d data=%h sop=%b eop=%b err=%b crc=%b, required chan=%0d data=%h sop=%b eop=%b err=%b crc=%b",
                                 out_chan, out_data, out_sop, out_eop, out_error, out_crc_pass,
                                 mon_e.chan, mon_e.data, mon_e.sop, mon_e.eop, mon_e.err, mon_e.crc);
                    end
                end
            end
        end
    end

    task automatic push_pkt(input int c, input int n, input logic [7:0] base, input logic crc,
                            input bit sop_first, input bit expect_out);
        beat_t b;
        for (int k = 0; k < n; k++) begin
            b.chan = CW'(c);
            b.data = 8'(base + 8'(k * 17));
            b.sop  = (k == 0) && sop_first;
            b.eop  = (k == n - 1);
            b.err  = 2'(c + k);
            b.crc  = crc;
            srcq[c].push_back(b);
            if (expect_out) expq.push_back(b);
        end
    endtask

    task automatic wait_drain(input int budget, input string name);
        int cyc;
        cyc = 0;
        while ((expq.size() != 0 || out_valid) && cyc < budget) begin
            @(posedge clk);
            #2;
            cyc++;
        end
        n_tests++;
        if (expq.size() != 0 || out_valid) begin
            n_fail++;
            $display("FAIL %s_drain: got %0d beats outstanding after %0d cycles, required 0", name, expq.size(), budget);
        end
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < N; c++) srcq[c].delete();
        expq.delete();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        n_tests++;
        if ({out_valid, out_sop, out_eop, out_error, out_crc_pass, out_data, out_chan} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b data=%h chan=%0d, required all 0", out_valid, out_data, out_chan);
        end
        n_tests++;
        if (src_ready !== '0) begin
            n_fail++;
            $display("FAIL reset_src_ready: got %b, required 0000", src_ready);
        end
        n_tests++;
        if (proto_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_proto_err: got %b, required 0", proto_err);
        end
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        n_tests++;
        if ({out_valid, src_ready, proto_err} !== '0) begin
            n_fail++;
            $display("FAIL idle_quiet: got v=%b rdy=%b perr=%b, required 0", out_valid, src_ready, proto_err);
        end
`ifdef TURBO_ARB_STATS_EN
        n_tests++;
        if ({pkt_cnt, crc_fail_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_stats: got %h %h, required 0", pkt_cnt, crc_fail_cnt);
        end
`endif
    endtask

    task automatic test_single();
        int cyc;
        do_reset();
        push_pkt(2, 3, 8'h11, 1'b1, 1'b1, 1'b1);
        cyc = 0;
        while (!src_valid[2] && cyc < 10) begin
            @(posedge clk);
            #2;
            cyc++;
        end
        cyc = 0;
        while (!out_valid && cyc < 10) begin
            @(posedge clk);
            #2;
            cyc++;
        end
        n_tests++;
        if (cyc != 2) begin
            n_fail++;
            $display("FAIL single_latency: got %0d cycles, required 2", cyc);
        end
        n_tests++;
        if ({out_sop, out_chan, out_data} !== {1'b1, 4'd2, 8'h11}) begin
            n_fail++;
            $display("FAIL single_first_beat: got sop=%b chan=%0d data=%h, required sop=1 chan=2 data=11", out_sop, out_chan, out_data);
        end
        wait_drain(20, "single");
        n_tests++;
        if (proto_err !== 1'b0) begin
            n_fail++;
            $display("FAIL single_proto_err: got %b, required 0", proto_err);
        end
    endtask

    task automatic test_all_four();
        do_reset();
        for (int c = 0; c < N; c++) push_pkt(c, 2, 8'(8'h40 + c * 32), 1'(c % 2), 1'b1, 1'b1);
        push_pkt(0, 2, 8'hB0, 1'b1, 1'b1, 1'b1);
        wait_drain(60, "all_four");
        n_tests++;
        if (proto_err !== 1'b0) begin
            n_fail++;
            $display("FAIL all_four_proto_err: got %b, required 0", proto_err);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] pat;
        int cyc;
        pat = 8'b1111_1001;
        do_reset();
        push_pkt(1, 5, 8'hA0, 1'b0, 1'b1, 1'b1);
        cyc = 0;
        while (!out_valid && cyc < 10) begin
            @(posedge clk);
            #2;
            cyc++;
        end
        for (int k = 0; k < 8; k++) begin
            out_ready = pat[k];
            #1;
            if (out_valid && !out_ready) begin
                n_tests++;
                if (src_ready !== '0) begin
                    n_fail++;
                    $display("FAIL stall_src_ready: got %b, required 0000", src_ready);
                end
                if (expq.size() > 0) begin
                    n_tests++;
                    if (out_data !== expq[0].data) begin
                        n_fail++;
                        $display("FAIL stall_data: got %h, required %h", out_data, expq[0].data);
                    end
                end
            end
            @(posedge clk);
            #2;
        end
        out_ready = 1'b1;
        wait_drain(30, "backpressure");
    endtask

    task automatic test_single_beat();
        do_reset();
        push_pkt(1, 1, 8'h51, 1'b1, 1'b1, 1'b1);
        wait_drain(20, "prime_ptr");
        push_pkt(3, 1, 8'h73, 1'b1, 1'b1, 1'b1);
        push_pkt(1, 1, 8'h31, 1'b0, 1'b1, 1'b1);
        wait_drain(20, "single_beat");
        push_pkt(2, 1, 8'h82, 1'b1, 1'b1, 1'b1);
        push_pkt(1, 1, 8'h91, 1'b1, 1'b1, 1'b1);
        wait_drain(20, "ptr_after");
    endtask

    task automatic test_proto();
        beat_t b;
        do_reset();
        push_pkt(0, 1, 8'hEE, 1'b1, 1'b0, 1'b0);
        push_pkt(1, 2, 8'h61, 1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #2;
            n_tests++;
            if (src_ready[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL nosop_granted: got src_ready[0]=%b, required 0", src_ready[0]);
            end
        end
        wait_drain(20, "proto_idle");
        n_tests++;
        if (proto_err !== 1'b1) begin
            n_fail++;
            $display("FAIL proto_idle_flag: got %b, required 1", proto_err);
        end
        n_tests++;
        if (srcq[0].size() != 1) begin
            n_fail++;
            $display("FAIL nosop_consumed: got %0d beats left on ch0, required 1", srcq[0].size());
        end
        do_reset();
        for (int k = 0; k < 3; k++) begin
            b.chan = 4'd2;
            b.data = 8'(8'hE0 + k);
            b.sop  = (k < 2);
            b.eop  = (k == 2);
            b.err  = 2'(k);
            b.crc  = 1'b1;
            srcq[2].push_back(b);
            expq.push_back(b);
        end
        wait_drain(20, "proto_busy");
        n_tests++;
        if (proto_err !== 1'b1) begin
            n_fail++;
            $display("FAIL proto_busy_flag: got %b, required 1", proto_err);
        end
    endtask

    task automatic test_reset_mid();
        beat_t b;
        int cyc;
        do_reset();
        push_pkt(2, 4, 8'hC0, 1'b1, 1'b1, 1'b1);
        cyc = 0;
        while (!out_valid && cyc < 10) begin
            @(posedge clk);
            #2;
            cyc++;
        end
        #1;
        reset_n = 1'b0;
        for (int c = 0; c < N; c++) srcq[c].delete();
        expq.delete();
        #1;
        n_tests++;
        if ({out_valid, out_sop, out_eop, out_error, out_crc_pass, out_data, out_chan, src_ready} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got v=%b data=%h chan=%0d rdy=%b, required all 0", out_valid, out_data, out_chan, src_ready);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #2;
        b.chan = 4'd2;
        b.data = 8'hC2;
        b.sop  = 1'b0;
        b.eop  = 1'b0;
        b.err  = 2'd0;
        b.crc  = 1'b1;
        srcq[2].push_back(b);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #2;
            n_tests++;
            if ({out_valid, src_ready} !== '0) begin
                n_fail++;
                $display("FAIL resume_without_sop: got v=%b rdy=%b, required 0", out_valid, src_ready);
            end
        end
        srcq[2].delete();
        push_pkt(2, 2, 8'hD0, 1'b1, 1'b1, 1'b1);
        wait_drain(20, "reset_mid");
    endtask

`ifdef TURBO_ARB_STATS_EN
    task automatic test_stats();
        logic [4:0] crc_pat;
        crc_pat = 5'b10101;
        do_reset();
        for (int p = 0; p < 5; p++) push_pkt(1, 2, 8'(8'h10 + p * 2), crc_pat[p], 1'b1, 1'b1);
        wait_drain(60, "stats");
        n_tests++;
        if (pkt_cnt[31:16] !== 16'd5) begin
            n_fail++;
            $display("FAIL stats_pkt_cnt1: got %0d, required 5", pkt_cnt[31:16]);
        end
        n_tests++;
        if (crc_fail_cnt[31:16] !== 16'd2) begin
            n_fail++;
            $display("FAIL stats_crc_fail1: got %0d, required 2", crc_fail_cnt[31:16]);
        end
        n_tests++;
        if ({pkt_cnt[63:32], pkt_cnt[15:0]} !== '0) begin
            n_fail++;
            $display("FAIL stats_other_chans: got %h, required 0", pkt_cnt);
        end
    endtask
`endif

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        acc       = '0;
        reset_n   = 1'b0;
        out_ready = 1'b1;
        drive_src();
        test_reset();
        test_single();
        test_all_four();
        test_backpressure();
        test_single_beat();
        test_proto();
        test_reset_mid();
`ifdef TURBO_ARB_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
